// File: rtl/distance_filter_pkg.sv
// Shared zone encodings and default tuning constants for the distance filter.
package distance_pkg;

  typedef enum logic [1:0] {
    ZONE_NONE = 2'd0,
    ZONE_NEAR = 2'd1,
    ZONE_MID  = 2'd2,
    ZONE_FAR  = 2'd3
  } zone_e;

  localparam int unsigned DEPTH_DEF          = 4;
  localparam int unsigned MIN_CM_DEF         = 2;
  localparam int unsigned MAX_CM_DEF         = 200;
  localparam int unsigned NEAR_CM_DEF        = 20;
  localparam int unsigned FAR_CM_DEF         = 100;
  localparam int unsigned HYST_CM_DEF        = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 5_000_000;

endpackage

// File: rtl/distance_filter_if.sv
// Sample-in / filtered-result-out bundle between the sensor stage and the filter.
interface distance_filter_if;
  logic                  sample_valid;
  logic [7:0]            sample;
  logic                  out_valid;
  logic [7:0]            out_distance;
  distance_pkg::zone_e   zone;
  logic                  stale;

  modport master (
    output sample_valid, sample,
    input  out_valid, out_distance, zone, stale
  );

  modport slave (
    input  sample_valid, sample,
    output out_valid, out_distance, zone, stale
  );
endinterface

// File: rtl/distance_filter_sample_window.sv
// Circular sample buffer with running sum; exposes the post-update average and fill state.
module sample_window
  import distance_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       flush_i,
  input  logic       wr_en_i,
  input  logic [7:0] din_i,
  output logic [7:0] avg_d_o,
  output logic       full_d_o
);

  localparam int unsigned LOG   = $clog2(DEPTH);
  localparam int unsigned SW    = 8 + LOG;
  localparam int unsigned PTR_W = (DEPTH > 1) ? LOG : 1;
  localparam int unsigned FW    = LOG + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [7:0]       evicted;

  // Once full, the slot about to be overwritten holds the oldest sample.
  assign evicted = (fill_q == FW'(DEPTH)) ? mem_q[ptr_q] : '0;

  always_comb begin
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (wr_en_i) begin
      sum_d  = sum_q + SW'(din_i) - SW'(evicted);
      ptr_d  = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      fill_d = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + 1'b1;
    end else if (flush_i) begin
      ptr_d  = '0;
      sum_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[ptr_q] <= din_i;
  end

  assign avg_d_o  = sum_d[LOG +: 8];
  assign full_d_o = (fill_d == FW'(DEPTH));

endmodule

// File: rtl/distance_filter.sv
// Range-gated moving-average distance filter with hysteretic proximity zones and stale timeout.
module distance_filter
  import distance_pkg::*;
#(
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned MIN_CM         = MIN_CM_DEF,
  parameter int unsigned MAX_CM         = MAX_CM_DEF,
  parameter int unsigned NEAR_CM        = NEAR_CM_DEF,
  parameter int unsigned FAR_CM         = FAR_CM_DEF,
  parameter int unsigned HYST_CM        = HYST_CM_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clock,
  input  logic            resetn,
  distance_filter_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          accept, timeout, flush, emit, full_d;
  logic [7:0]    avg_d;
  logic [31:0]   avg32, sample32;
  logic [TW-1:0] timer_q, timer_d;
  logic          out_valid_q, stale_q;
  logic [7:0]    out_distance_q;
  zone_e         zone_q, zone_d;

  assign sample32 = 32'(bus.sample);
  assign accept   = bus.sample_valid && (sample32 >= MIN_CM) && (sample32 <= MAX_CM);
  assign timeout  = (timer_q == TW'(TIMEOUT_CYCLES));
  // An accepted sample in the timeout cycle suppresses the flush.
  assign flush    = timeout && !accept;
  assign emit     = accept && full_d;
  assign avg32    = 32'(avg_d);

  sample_window #(.DEPTH(DEPTH)) u_window (
    .clock    (clock),
    .resetn   (resetn),
    .flush_i  (flush),
    .wr_en_i  (accept),
    .din_i    (bus.sample),
    .avg_d_o  (avg_d),
    .full_d_o (full_d)
  );

  always_comb begin
    timer_d = timer_q;
    if (accept)        timer_d = '0;
    else if (!timeout) timer_d = timer_q + 1'b1;
  end

  // Farther-zone transitions need HYST_CM of margin; nearer ones do not.
  always_comb begin
    zone_d = zone_q;
    if (flush) begin
      zone_d = ZONE_NONE;
    end else if (emit) begin
      case (zone_q)
        ZONE_NONE: begin
          if (avg32 < NEAR_CM)     zone_d = ZONE_NEAR;
          else if (avg32 < FAR_CM) zone_d = ZONE_MID;
          else                     zone_d = ZONE_FAR;
        end
        ZONE_NEAR: begin
          if (avg32 >= FAR_CM + HYST_CM)       zone_d = ZONE_FAR;
          else if (avg32 >= NEAR_CM + HYST_CM) zone_d = ZONE_MID;
        end
        ZONE_MID: begin
          if (avg32 < NEAR_CM)                 zone_d = ZONE_NEAR;
          else if (avg32 >= FAR_CM + HYST_CM)  zone_d = ZONE_FAR;
        end
        ZONE_FAR: begin
          if (avg32 < NEAR_CM)     zone_d = ZONE_NEAR;
          else if (avg32 < FAR_CM) zone_d = ZONE_MID;
        end
        default: zone_d = ZONE_NONE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      zone_q <= ZONE_NONE;
    end else begin
      zone_q <= zone_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timer_q        <= '0;
      out_valid_q    <= 1'b0;
      out_distance_q <= '0;
      stale_q        <= 1'b1;
    end else begin
      timer_q     <= timer_d;
      out_valid_q <= emit;
      if (emit) begin
        out_distance_q <= avg_d;
        stale_q        <= 1'b0;
      end else if (flush) begin
        stale_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_distance = out_distance_q;
  assign bus.zone         = zone_q;
  assign bus.stale        = stale_q;

endmodule

// File: tb/tb_distance_filter.sv
// Directed checks of averaging, range gating, zone hysteresis, timeout and reset.
module tb_distance_filter;
  import distance_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  distance_filter_if a_if ();
  distance_filter_if b_if ();

  distance_filter #(.DEPTH(4), .TIMEOUT_CYCLES(20)) dut_a (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (a_if)
  );

  distance_filter #(.DEPTH(1), .TIMEOUT_CYCLES(1000)) dut_b (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (b_if)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [7:0] s);
    @(negedge clk);
    a_if.sample_valid = 1'b1;
    a_if.sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic [7:0] s);
    @(negedge clk);
    b_if.sample_valid = 1'b1;
    b_if.sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [7:0] d,
                       input logic [1:0] z, input logic st);
    chk({tag, ".valid"}, 32'(a_if.out_valid), 32'(v));
    chk({tag, ".dist"},  32'(a_if.out_distance), 32'(d));
    chk({tag, ".zone"},  32'(a_if.zone), 32'(z));
    chk({tag, ".stale"}, 32'(a_if.stale), 32'(st));
  endtask

  // sample, out_valid, out_distance, zone, stale after each accepted/rejected sample
  int unsigned tbl_s  [20] = '{10, 20, 30, 40, 50,  0, 250,  2, 200,  1, 201,  5,  5,  5, 5, 21, 21, 21, 21, 30};
  int unsigned tbl_v  [20] = '{ 0,  0,  0,  1,  1,  0,   0,  1,   1,  0,   0,  1,  1,  1, 1,  1,  1,  1,  1,  1};
  int unsigned tbl_d  [20] = '{ 0,  0,  0, 25, 35, 35,  35, 30,  73, 73,  73, 64, 53, 53, 5,  9, 13, 17, 21, 23};
  int unsigned tbl_z  [20] = '{ 0,  0,  0,  2,  2,  2,   2,  2,   2,  2,   2,  2,  2,  2, 1,  1,  1,  1,  1,  2};
  int unsigned tbl_st [20] = '{ 1,  1,  1,  0,  0,  0,   0,  0,   0,  0,   0,  0,  0,  0, 0,  0,  0,  0,  0,  0};

  int unsigned b_s [5] = '{50, 100, 101, 102, 99};
  int unsigned b_z [5] = '{ 2,   2,   2,   3,  2};

  initial begin
    a_if.sample_valid = 1'b0;
    a_if.sample       = '0;
    b_if.sample_valid = 1'b0;
    b_if.sample       = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 1'b0, 8'd0, 2'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive_a(8'(tbl_s[i]));
      chk_a($sformatf("tbl%0d", i), 1'(tbl_v[i]), 8'(tbl_d[i]), 2'(tbl_z[i]), 1'(tbl_st[i]));
    end

    a_if.sample_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pulse_one_cycle", 32'(a_if.out_valid), 32'd0);
    repeat (19) @(posedge clk);
    #1;
    chk("pre_timeout.stale", 32'(a_if.stale), 32'd0);
    @(posedge clk);
    #1;
    chk("timeout.stale", 32'(a_if.stale), 32'd1);
    chk("timeout.zone", 32'(a_if.zone), 32'(ZONE_NONE));

    for (int i = 0; i < 3; i++) begin
      drive_a(8'd40);
      chk($sformatf("refill%0d.valid", i), 32'(a_if.out_valid), 32'd0);
      chk($sformatf("refill%0d.stale", i), 32'(a_if.stale), 32'd1);
    end
    drive_a(8'd40);
    chk_a("refill3", 1'b1, 8'd40, 2'd2, 1'b0);

    a_if.sample_valid = 1'b0;
    repeat (20) @(posedge clk);
    drive_a(8'd60);
    chk_a("timeout_race", 1'b1, 8'd45, 2'd2, 1'b0);
    a_if.sample_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("timer_cleared.stale", 32'(a_if.stale), 32'd0);

    drive_a(8'd100);
    chk_a("pre_rst0", 1'b1, 8'd60, 2'd2, 1'b0);
    drive_a(8'd100);
    chk_a("pre_rst1", 1'b1, 8'd75, 2'd2, 1'b0);
    a_if.sample_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 1'b0, 8'd0, 2'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(8'd120);
      chk($sformatf("post_rst%0d.valid", i), 32'(a_if.out_valid), 32'd0);
    end
    drive_a(8'd120);
    chk_a("post_rst3", 1'b1, 8'd120, 2'd3, 1'b0);
    a_if.sample_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive_b(8'(b_s[i]));
      chk($sformatf("d1_%0d.valid", i), 32'(b_if.out_valid), 32'd1);
      chk($sformatf("d1_%0d.dist", i), 32'(b_if.out_distance), b_s[i]);
      chk($sformatf("d1_%0d.zone", i), 32'(b_if.zone), b_z[i]);
    end
    b_if.sample_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
DISTANCE_FILTER -- requirements
Module: distance_filter

Interface
REQ-001 Parameter DEPTH, default 4: averaging window length in samples; power of two, 1..16.
REQ-002 Parameter MIN_CM, default 2: smallest accepted sample, in cm.
REQ-003 Parameter MAX_CM, default 200: largest accepted sample, in cm.
REQ-004 Parameter NEAR_CM, default 20: upper bound of the NEAR zone.
REQ-005 Parameter FAR_CM, default 100: lower bound of the FAR zone.
REQ-006 Parameter HYST_CM, default 2: hysteresis applied when moving to a farther zone.
REQ-007 Parameter TIMEOUT_CYCLES, default 5_000_000: stale timeout, 100 ms at 50 MHz.
REQ-008 clock  input  1  rising-edge system clock; all state is clocked by this single clock.
REQ-009 resetn  input  1  reset; asynchronous and active-low.
REQ-010 sample_valid  input  1  one-cycle strobe marking a new raw distance from the ultrasonic sensor stage.
REQ-011 sample  input  8  raw distance in cm, qualified by sample_valid.
REQ-012 out_valid  output  1  one-cycle strobe marking a new filtered result.
REQ-013 out_distance  output  8  filtered distance in cm; held between strobes.
REQ-014 zone  output  2  proximity class: NONE=0, NEAR=1, MID=2, FAR=3.
REQ-015 stale  output  1  high when no valid average exists.

Function
REQ-016 A sample is accepted on a rising edge when sample_valid=1 and MIN_CM <= sample <= MAX_CM.
REQ-017 A sample outside that range is discarded: no window update, no out_valid, and no timer reset.
REQ-018 Accepted samples are written into a circular buffer of DEPTH entries; the write pointer wraps from DEPTH-1 to 0.
REQ-019 The running sum is 8+log2(DEPTH) bits wide and updates as sum + new - evicted in the accepting cycle; it never overflows.
REQ-020 The fill count saturates at DEPTH; while the window is not full, accepted samples produce no output.
REQ-021 When an accepted sample leaves the window full, out_valid=1 on the next cycle and out_distance = updated sum >> log2(DEPTH) (truncating). Latency is 1 cycle.
REQ-022 Back-to-back sample_valid on consecutive cycles is legal; each accepted sample gives its own out_valid.
REQ-023 The timeout counter clears on every accepted sample and otherwise increments; the counter saturates.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES, the window is flushed (fill=0, sum=0, pointer=0), stale goes to 1, and zone goes to NONE.
REQ-025 If an accepted sample arrives in the same cycle the timeout is reached, the sample wins: the timer clears and no flush occurs.
REQ-026 stale clears in the same cycle that out_valid asserts.
REQ-027 The zone FSM updates only in the out_valid cycle, using the new out_distance (avg below):
- from NONE: avg < NEAR_CM gives NEAR; otherwise avg < FAR_CM gives MID; otherwise FAR.
- from NEAR: avg >= FAR_CM+HYST_CM gives FAR; otherwise avg >= NEAR_CM+HYST_CM gives MID; otherwise stay NEAR.
- from MID: avg < NEAR_CM gives NEAR; otherwise avg >= FAR_CM+HYST_CM gives FAR; otherwise stay MID.
- from FAR: avg < NEAR_CM gives NEAR; otherwise avg < FAR_CM gives MID; otherwise stay FAR.

Reset
REQ-028 Asserting resetn=0 immediately forces: out_valid=0, out_distance=0, zone=NONE, stale=1, sum=0, fill=0, pointer=0, timer=0.
REQ-029 Buffer contents need no reset; they are never read before being written.
REQ-030 Reset asserted mid-stream discards any partial window; after release, DEPTH new accepted samples are required before out_valid.

Structure
REQ-031 Zone encodings and default parameter constants shall live in the shared package distance_pkg.
REQ-032 The circular buffer and running sum shall be the sub-module sample_window; the zone FSM and timeout counter stay in distance_filter.

Verification
REQ-033 Reset; samples 10,20,30,40 -> out_valid only 1 cycle after the 40; out_distance=25, zone=MID, stale=0.
REQ-034 Continue with sample 50 -> out_distance=35; then sample 0 and sample 250 -> no out_valid and out_distance stays 35.
REQ-035 DEPTH=1; samples 50,100,101,102,99 -> zone MID,MID,MID,FAR,MID.
REQ-036 Full window, then idle for TIMEOUT_CYCLES -> stale=1, zone=NONE; the next 3 samples give no out_valid; the 4th does.
REQ-037 sample_valid with sample=60 in the exact timeout cycle -> no flush; out_valid follows 1 cycle later; stale unchanged.
REQ-038 resetn pulsed low between the 2nd and 3rd samples -> outputs reset immediately; the first out_valid comes only after 4 post-reset samples.
